// File: rtl/out_port_fifo_if.sv
// CPU-side write port, per-channel drain handshake and status of the buffered output port.
interface out_port_fifo_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                      clk_en;
  logic                      i_load_enable;
  logic [CH_W-1:0]           i_channel;
  logic [WIDTH-1:0]          i_load_data;
  logic                      o_stall;
  logic [CHANNELS-1:0]       o_valid;
  logic [CHANNELS-1:0]       i_ready;
  logic [CHANNELS*WIDTH-1:0] o_data;
  logic [CHANNELS*WIDTH-1:0] o_last;
  logic [CHANNELS*LVL_W-1:0] o_level;
  logic                      i_clear_err;
  logic [CHANNELS-1:0]       o_overflow;
  logic                      o_bad_channel;

  modport master (
    output clk_en, i_load_enable, i_channel, i_load_data, i_ready, i_clear_err,
    input  o_stall, o_valid, o_data, o_last, o_level, o_overflow, o_bad_channel
  );

  modport slave (
    input  clk_en, i_load_enable, i_channel, i_load_data, i_ready, i_clear_err,
    output o_stall, o_valid, o_data, o_last, o_level, o_overflow, o_bad_channel
  );
endinterface

// File: rtl/out_port_fifo.sv
// Multi-channel buffered output port: CPU pushes into per-channel circular FIFOs,
// each channel drains independently over valid/ready; full channel raises a stall.
module out_port_fifo #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  out_port_fifo_if.slave bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r    [CHANNELS][DEPTH];
  logic [PTR_W-1:0] rd_ptr_r [CHANNELS];
  logic [PTR_W-1:0] wr_ptr_r [CHANNELS];
  logic [LVL_W-1:0] level_r  [CHANNELS];
  logic [WIDTH-1:0] last_r   [CHANNELS];
  logic [CHANNELS-1:0] overflow_r;
  logic                bad_channel_r;

  logic [CHANNELS-1:0] sel_s;
  logic [CHANNELS-1:0] full_s;
  logic [CHANNELS-1:0] push_s;
  logic [CHANNELS-1:0] reject_s;
  logic [CHANNELS-1:0] pop_s;
  logic                write_s;
  logic                bad_s;

  // Per-channel push/pop/reject decode; full is taken from the pre-pop level.
  always_comb begin
    write_s = bus.clk_en && bus.i_load_enable;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_s[k]    = bus.i_load_enable && (bus.i_channel == CH_W'(k));
      full_s[k]   = (level_r[k] == LVL_W'(DEPTH));
      push_s[k]   = bus.clk_en && sel_s[k] && !full_s[k];
      reject_s[k] = bus.clk_en && sel_s[k] && full_s[k];
      pop_s[k]    = (level_r[k] != {LVL_W{1'b0}}) && bus.i_ready[k];
    end
    // No channel matched the index: it lies beyond the implemented channels.
    bad_s = write_s && (sel_s == {CHANNELS{1'b0}});
  end

  // Pointer, level and last-written registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        rd_ptr_r[k] <= {PTR_W{1'b0}};
        wr_ptr_r[k] <= {PTR_W{1'b0}};
        level_r[k]  <= {LVL_W{1'b0}};
        last_r[k]   <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push_s[k]) begin
          wr_ptr_r[k] <= wr_ptr_r[k] + PTR_W'(1);
          last_r[k]   <= bus.i_load_data;
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= rd_ptr_r[k] + PTR_W'(1);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   level_r[k] <= level_r[k] + LVL_W'(1);
          2'b01:   level_r[k] <= level_r[k] - LVL_W'(1);
          default: level_r[k] <= level_r[k];
        endcase
      end
    end
  end

  // Storage array; contents survive reset since the level gates visibility.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k]] <= bus.i_load_data;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r    <= {CHANNELS{1'b0}};
      bad_channel_r <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (reject_s[k]) begin
          overflow_r[k] <= 1'b1;
        end else if (bus.clk_en && bus.i_clear_err) begin
          overflow_r[k] <= 1'b0;
        end
      end
      if (bad_s) begin
        bad_channel_r <= 1'b1;
      end else if (bus.clk_en && bus.i_clear_err) begin
        bad_channel_r <= 1'b0;
      end
    end
  end

  // Output packing; stall depends only on the request and the registered level.
  always_comb begin
    bus.o_stall       = |(sel_s & full_s);
    bus.o_overflow    = overflow_r;
    bus.o_bad_channel = bad_channel_r;
    bus.o_valid       = {CHANNELS{1'b0}};
    bus.o_data        = {(CHANNELS*WIDTH){1'b0}};
    bus.o_last        = {(CHANNELS*WIDTH){1'b0}};
    bus.o_level       = {(CHANNELS*LVL_W){1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      bus.o_valid[k]                 = (level_r[k] != {LVL_W{1'b0}});
      bus.o_last[k*WIDTH +: WIDTH]   = last_r[k];
      bus.o_level[k*LVL_W +: LVL_W]  = level_r[k];
      if (level_r[k] != {LVL_W{1'b0}}) begin
        bus.o_data[k*WIDTH +: WIDTH] = mem_r[k][rd_ptr_r[k]];
      end else begin
        bus.o_data[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end
endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Buffered, multi-channel output port for the SAP2 CPU, replacing the single-register output stage behind `OI`. The CPU writes a word from the bus into one of `CHANNELS` independent FIFOs; each channel drains to an external consumer over a valid/ready handshake. When the addressed channel is full, a stall request lets the top level freeze the instruction step, so no data is lost. Per-channel level, last-written value and sticky error flags are exported for the simulator and display logic.

## Interface
- `WIDTH`, 16, data word width; matches the bus and output width.
- `CHANNELS`, 4, number of output channels; must be ≥1.
- `DEPTH`, 8, entries per channel FIFO; power of two, ≥2.
- `CH_W` (localparam), `CHANNELS>1 ? $clog2(CHANNELS) : 1`, channel select width.
- `LVL_W` (localparam), `$clog2(DEPTH+1)`, level counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  CPU-side clock enable from the clock-enable block; qualifies writes and error-flag clears only.
- `i_load_enable`  in  1  write request (control word `OI`).
- `i_channel`  in  `CH_W`  target channel for the write.
- `i_load_data`  in  `WIDTH`  write data, from the bus.
- `o_stall`  out  1  combinational: `i_load_enable` and the addressed channel is full.
- `o_valid`  out  `CHANNELS`  per channel: head word present.
- `i_ready`  in  `CHANNELS`  per channel: consumer accepts the head word.
- `o_data`  out  `CHANNELS*WIDTH`  head word per channel; channel k occupies `[k*WIDTH +: WIDTH]`.
- `o_last`  out  `CHANNELS*WIDTH`  last word accepted per channel; same packing.
- `o_level`  out  `CHANNELS*LVL_W`  occupancy per channel, 0..DEPTH.
- `i_clear_err`  in  1  clears all sticky error flags; qualified by `clk_en`.
- `o_overflow`  out  `CHANNELS`  sticky: a write to this channel was rejected because it was full.
- `o_bad_channel`  out  1  sticky: a write addressed a channel index ≥ `CHANNELS`.

## Operation
- Each channel is a circular buffer with read and write pointers (`$clog2(DEPTH)` bits, wrap modulo DEPTH) and a level counter; full means level == DEPTH, empty means level == 0.
- Push: on `clk_en && i_load_enable`, a valid channel that is not full stores `i_load_data` at its write pointer and updates `o_last`. The write pointer advances and the level increments.
- Rejected push: if the channel is full, nothing is stored, the pointers are unchanged, and `o_overflow[ch]` is set. `o_stall` is already high in that cycle, so a correctly wired top level never produces an overflow.
- Bad channel: the write is dropped and `o_bad_channel` is set. `o_stall` stays 0.
- Pop: on any `clk` edge (not gated by `clk_en`), every channel with `o_valid[k] && i_ready[k]` advances its read pointer and decrements its level. Channels pop independently and simultaneously.
- `o_valid[k]` = (level ≠ 0). `o_data` slice = the entry at the read pointer when valid, otherwise all zeros.
- Full is evaluated before a pop in the same cycle: a push to a full channel is rejected even if that channel pops on the same edge. This keeps `i_ready` out of the `o_stall` path.
- Push and pop on the same non-full, non-empty channel in one edge: both take effect and the level is unchanged.
- Push to an empty channel with `i_ready` high: no pop that edge. The word becomes valid next cycle.
- Error handling: when `clk_en && i_clear_err` coincides with a new error, the set wins.

## Timing
- Reset (asynchronous): all pointers and levels go to 0; `o_valid`=0, `o_data`=0, `o_last`=0, `o_level`=0, `o_overflow`=0, `o_bad_channel`=0. `o_stall` then follows its inputs combinationally. Storage contents are not reset.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock.
- Write-to-visible latency: 1 clock. A word pushed at edge N has `o_valid`=1 and `o_data` equal to that word after edge N.
- Pop takes effect at the edge where valid && ready. The next head word is presented in the following cycle, giving 1 word/cycle per channel of sustained throughput.
- `o_stall` is combinational from `i_load_enable`, `i_channel` and the registered level. It has no path from `i_ready`.
- `o_level`, `o_last` and the error flags are all registered.

## Test plan
- Reset then idle: all outputs are 0. Write 0x1234 to ch0 with `clk_en`=1 → next cycle `o_valid[0]`=1, `o_data[0]`=0x1234, `o_level[0]`=1, `o_last[0]`=0x1234.
- Fill ch2 with 8 words (0xA0..0xA7) while `i_ready`=0 → `o_level[2]`=8. A 9th write gives `o_stall`=1 and, if forced, sets `o_overflow[2]` with level still 8. Raising `i_ready[2]` drains 0xA0..0xA7 in order, one per cycle.
- Wrap-around: push 5 and pop 5, repeated 4 times on ch1 with distinct data → output order is preserved across pointer wrap and the final level is 0.
- Push and pop on the same edge on ch3 at level 3 → level stays 3 and FIFO order is intact. At level 8, the push is rejected, the pop occurs, and the level becomes 7.
- With `CHANNELS`=3, write to channel 3 → `o_bad_channel`=1 and no level changes. `i_clear_err` with `clk_en`=1 clears the flag; with `clk_en`=0 it does not.
- Assert `rst_n`=0 between clock edges while ch0 holds 4 words → outputs go to zero immediately, and after release `o_valid`=0.
